// File: rtl/alu_result_accumulator.sv
// Frame accumulator behind the ALU stage: sums len signed results, clamps to NBITS+1 bits.
// Optional ReLU on the frame result when ACT_RELU_EN is defined.
module alu_result_accumulator #(
    parameter int unsigned NBITS = 15,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS+1:0] in_y,
    input  logic             in_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS:0]   out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_co_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [NBITS:0]   OutMax = {1'b0, {NBITS{1'b1}}};
    localparam logic [NBITS:0]   OutMin = {1'b1, {NBITS{1'b0}}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] co_cnt_q, co_cnt_d;
    logic [NBITS:0]   out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic [CNT_W-1:0] out_co_q, out_co_d;

    logic [ACC_W:0]       sum_ext;
    logic                 acc_ovf;
    logic [ACC_W-1:0]     acc_add;
    logic [ACC_W-NBITS-1:0] acc_upper;
    logic                 clamp_hi, clamp_lo;
    logic [NBITS:0]       final_data;
    logic [CNT_W-1:0]     co_next;
    logic                 load;

    // One guard bit detects signed overflow of the ACC_W-bit accumulator.
    always_comb begin
        sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-NBITS-1){in_y[NBITS+1]}}, in_y};
        acc_ovf = sum_ext[ACC_W] != sum_ext[ACC_W-1];
        if (acc_ovf) begin
            acc_add = sum_ext[ACC_W] ? AccMin : AccMax;
        end else begin
            acc_add = sum_ext[ACC_W-1:0];
        end
        acc_upper = acc_add[ACC_W-1:NBITS];
        clamp_hi  = !acc_add[ACC_W-1] && (|acc_upper);
        clamp_lo  = acc_add[ACC_W-1] && !(&acc_upper);
        if (clamp_hi) begin
            final_data = OutMax;
        end else if (clamp_lo) begin
            final_data = OutMin;
        end else begin
            final_data = acc_add[NBITS:0];
        end
`ifdef ACT_RELU_EN
        if (final_data[NBITS]) begin
            final_data = '0;
        end
`endif
        co_next = co_cnt_q + {{(CNT_W-1){1'b0}}, (in_co && !(&co_cnt_q))};
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        sat_d      = sat_q;
        co_cnt_d   = co_cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        out_co_d   = out_co_q;
        load       = 1'b0;
        unique case (state_q)
            StIdle: begin
                load = start;
            end
            StAccum: begin
                if (in_valid) begin
                    acc_d    = acc_add;
                    sat_d    = sat_q | acc_ovf;
                    co_cnt_d = co_next;
                    rem_d    = rem_q - CntOne;
                    if (rem_q == CntOne) begin
                        out_data_d = final_data;
                        out_sat_d  = sat_q | acc_ovf | clamp_hi | clamp_lo;
                        out_co_d   = co_next;
                        state_d    = StOutput;
                    end
                end
            end
            StOutput: begin
                if (out_ready) begin
                    load    = start;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new frame may start from IDLE or straight off the output handshake.
        if (load) begin
            rem_d    = len;
            acc_d    = '0;
            sat_d    = 1'b0;
            co_cnt_d = '0;
            if (len == '0) begin
                out_data_d = '0;
                out_sat_d  = 1'b0;
                out_co_d   = '0;
                state_d    = StOutput;
            end else begin
                state_d = StAccum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            rem_q      <= '0;
            sat_q      <= 1'b0;
            co_cnt_q   <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_co_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            sat_q      <= sat_d;
            co_cnt_q   <= co_cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_co_q   <= out_co_d;
        end
    end

    assign in_ready   = (state_q == StAccum);
    assign out_valid  = (state_q == StOutput);
    assign busy       = (state_q != StIdle);
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign out_co_cnt = out_co_q;

endmodule
